// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the fetch hazard sequencer
// Contents: sequencer state enum, opcode constants, instruction field indices,
// and reads_rt() which says whether an opcode sources the rt field.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] HALT_OP  = 6'b111111;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    // Only these formats read rt; for loads and other I-types rt is a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/raw_detect.sv
// rtl/raw_detect.sv - read-after-write match of the ID sources against EX/MEM destinations
// Ports: id_instr (instruction in IF/ID), ex_rd/ex_reg_write and mem_rd/mem_reg_write
// (producer destinations), raw_ex/raw_mem (combinational match flags).
module raw_detect (
    input  logic [31:0] id_instr,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    output logic        raw_ex,
    output logic        raw_mem
);
    import hazard_pkg::*;

    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       unused_bits;

    assign rs          = id_instr[RS_HI:RS_LO];
    assign rt          = id_instr[RT_HI:RT_LO];
    assign use_rt      = reads_rt(id_instr[OP_HI:OP_LO]);
    assign unused_bits = ^id_instr[15:0];

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign raw_ex  = ex_reg_write && (ex_rd != 5'd0) &&
                     ((ex_rd == rs) || (use_rt && (ex_rd == rt)));
    assign raw_mem = mem_reg_write && (mem_rd != 5'd0) &&
                     ((mem_rd == rs) || (use_rt && (mem_rd == rt)));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - fetch/decode pipeline sequencer for RAW stalls, branch flush and HALT
// Ports: clk, rst (sync active-high); id_instr, ex_rd, ex_reg_write, ex_mem_read,
// mem_rd, mem_reg_write, ex_branch_taken in; hazard (PC hold), ifid_hold,
// idex_bubble, flush, halted, stall_cnt (saturating stall cycle count) out.
// Build option: define HAZ_FORWARD_EN when the forwarding datapath exists, so
// only load-use stalls (1 cycle); otherwise EX RAW stalls 2 cycles, MEM RAW 1.
module fetch_hazard_ctrl #(
    parameter int         FLUSH_CYCLES = 1,
    parameter logic [5:0] HALT_OP      = hazard_pkg::HALT_OP,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             ex_branch_taken,
    output logic             hazard,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    import hazard_pkg::*;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             raw_ex, raw_mem;
    logic             stall_req, stall_more;
    logic             unused_ok;

    raw_detect u_raw_detect (
        .id_instr      (id_instr),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .raw_ex        (raw_ex),
        .raw_mem       (raw_mem)
    );

`ifdef HAZ_FORWARD_EN
    // Forwarding covers everything except a load feeding the very next instruction.
    assign stall_req  = ex_mem_read && raw_ex;
    assign stall_more = 1'b0;
    assign unused_ok  = ^{raw_mem, id_instr[25:0]};
`else
    // EX producer needs two held cycles to reach WB; MEM producer needs one.
    assign stall_req  = raw_ex || raw_mem;
    assign stall_more = raw_ex;
    assign unused_ok  = ^{ex_mem_read, id_instr[25:0]};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hazard      = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        if (state_q == ST_HALT) begin
            hazard      = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else if (ex_branch_taken) begin
            // PC must not be held so the redirect target loads this edge.
            flush   = 1'b1;
            cnt_d   = FLUSH_RELOAD;
            state_d = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            // ID content is being squashed, so it is not decoded for HALT/RAW.
            flush = 1'b1;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = ST_RUN;
        end else if (id_instr[OP_HI:OP_LO] == HALT_OP) begin
            hazard    = 1'b1;
            ifid_hold = 1'b1;
            state_d   = ST_HALT;
        end else if (state_q == ST_STALL) begin
            hazard      = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = ST_RUN;
        end else if (stall_req) begin
            hazard      = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            if (stall_more) begin
                state_d = ST_STALL;
                cnt_d   = 2'd1;
            end
        end
        // Outputs are quiet for the whole reset cycle regardless of inputs.
        if (rst) begin
            hazard      = 1'b0;
            ifid_hold   = 1'b0;
            idex_bubble = 1'b0;
            flush       = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hazard && !halted && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign stall_cnt = rst ? '0 : stall_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - directed-vector bench for fetch_hazard_ctrl
module tb_fetch_hazard_ctrl;

`ifdef HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_instr = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic        mem_reg_write = 1'b0;
    logic        ex_branch_taken = 1'b0;

    logic        hazard, ifid_hold, idex_bubble, flush, halted;
    logic [3:0]  stall_cnt;
    logic        d1_hazard, d1_ifid_hold, d1_idex_bubble, d1_flush, d1_halted;
    logic [15:0] d1_stall_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .ex_branch_taken(ex_branch_taken),
        .hazard(hazard), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .flush(flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    fetch_hazard_ctrl d1 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .ex_branch_taken(ex_branch_taken),
        .hazard(d1_hazard), .ifid_hold(d1_ifid_hold), .idex_bubble(d1_idex_bubble),
        .flush(d1_flush), .halted(d1_halted), .stall_cnt(d1_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_instr        = '0;
        ex_rd           = '0;
        ex_reg_write    = 1'b0;
        ex_mem_read     = 1'b0;
        mem_rd          = '0;
        mem_reg_write   = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, 5'd1, 11'd0};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b100011, rs, rt, 16'd0};
    endfunction

    initial begin
        // Reset: hazardous inputs present, outputs still quiet.
        id_instr = lw(5'd5, 5'd9); ex_rd = 5'd5; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("rst_hazard", hazard, 0);
        chk("rst_flush", flush, 0);
        chk("rst_bubble", idex_bubble, 0);
        tick();
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0; clear_in(); #1;
        chk("post_rst_hazard", hazard, 0);
        chk("post_rst_hold", ifid_hold, 0);

        // Register 0 never matches; load rt is a destination, not a source.
        id_instr = rtype(5'd0, 5'd0); ex_rd = 5'd0; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; mem_rd = 5'd0; mem_reg_write = 1'b1; #1;
        chk("r0_hazard", hazard, 0);
        clear_in(); id_instr = lw(5'd1, 5'd3); mem_rd = 5'd3; mem_reg_write = 1'b1; #1;
        chk("lw_rt_hazard", hazard, 0);
        clear_in();

        // Load-use on rs.
        do_reset();
        id_instr = lw(5'd5, 5'd9); ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; #1;
        chk("lu_c0_hazard", hazard, 1);
        chk("lu_c0_bubble", idex_bubble, 1);
        tick(); ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; #1;
        chk("lu_c1_hazard", hazard, FWD ? 0 : 1);
        tick();
        chk("lu_c2_hazard", hazard, 0);
        chk("lu_cnt", stall_cnt, FWD ? 1 : 2);

        // Non-load RAW on rt of an R-type, then MEM-only RAW.
        do_reset();
        id_instr = rtype(5'd1, 5'd3); ex_rd = 5'd3; ex_reg_write = 1'b1; #1;
        chk("rx_c0_hazard", hazard, FWD ? 0 : 1);
        tick(); ex_rd = 5'd0; ex_reg_write = 1'b0; #1;
        chk("rx_c1_hazard", hazard, FWD ? 0 : 1);
        tick();
        chk("rx_c2_hazard", hazard, 0);
        mem_rd = 5'd3; mem_reg_write = 1'b1; #1;
        chk("rm_c0_hazard", hazard, FWD ? 0 : 1);
        tick(); mem_rd = 5'd0; mem_reg_write = 1'b0; #1;
        chk("rm_c1_hazard", hazard, 0);
        chk("rx_rm_cnt", stall_cnt, FWD ? 0 : 3);

        // Branch beats a simultaneous load-use; FLUSH_CYCLES=2 vs default 1.
        do_reset();
        id_instr = lw(5'd5, 5'd9); ex_rd = 5'd5; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_branch_taken = 1'b1; #1;
        chk("br_c0_flush", flush, 1);
        chk("br_c0_hazard", hazard, 0);
        chk("br_c0_bubble", idex_bubble, 0);
        chk("br_c0_d1_flush", d1_flush, 1);
        tick(); clear_in(); #1;
        chk("br_c1_flush", flush, 1);
        chk("br_c1_hazard", hazard, 0);
        chk("br_c1_d1_flush", d1_flush, 0);
        tick();
        chk("br_c2_flush", flush, 0);
        chk("br_cnt", stall_cnt, 0);

        // HALT: entry cycle holds, then sticky until reset; branch ignored.
        do_reset();
        id_instr = {6'b111111, 26'd0}; #1;
        chk("h_c0_hazard", hazard, 1);
        chk("h_c0_hold", ifid_hold, 1);
        chk("h_c0_halted", halted, 0);
        tick();
        chk("h_c1_halted", halted, 1);
        chk("h_c1_bubble", idex_bubble, 1);
        ex_branch_taken = 1'b1; #1;
        chk("h_br_flush", flush, 0);
        chk("h_br_halted", halted, 1);
        tick(); clear_in(); #1;
        chk("h_c2_halted", halted, 1);
        chk("h_cnt", stall_cnt, 1);
        rst = 1'b1; #1;
        chk("h_rst_halted", halted, 0);
        chk("h_rst_cnt", stall_cnt, 0);
        tick(); rst = 1'b0; #1;
        chk("h_after_halted", halted, 0);
        chk("h_after_hazard", hazard, 0);

        // Saturation: 20 forced stall cycles.
        do_reset();
        id_instr = rtype(5'd7, 5'd8); ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        mem_rd = 5'd7; mem_reg_write = 1'b1;
        repeat (20) tick();
        chk("sat_cnt", stall_cnt, 15);
        chk("sat_d1_cnt", d1_stall_cnt, 20);
        tick();
        chk("sat_hold_cnt", stall_cnt, 15);
        chk("sat_d1_cnt2", d1_stall_cnt, 21);

        // Reset in the middle of a stall.
        do_reset();
        id_instr = rtype(5'd7, 5'd8); ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1; #1;
        chk("ms_c0_hazard", hazard, 1);
        tick();
        chk("ms_c1_hazard", hazard, 1);
        rst = 1'b1; #1;
        chk("ms_rst_hazard", hazard, 0);
        chk("ms_rst_bubble", idex_bubble, 0);
        tick(); rst = 1'b0; clear_in(); #1;
        chk("ms_after_hazard", hazard, 0);
        chk("ms_after_cnt", stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
